// File: rtl/fir_pkg.sv
// ============================================================================
// Module   : fir_pkg
// Purpose  : Shared sample type and rounding helper for the FIR output path.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package fir_pkg;

    localparam int SAMPLE_W = 16;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    // Half an LSB of the decimated result; zero when there is no decimation.
    function automatic int round_term(input int decim_log2);
        return (decim_log2 > 0) ? (1 << (decim_log2 - 1)) : 0;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fir_decim_out_if.sv
// ============================================================================
// Module   : fir_decim_out_if
// Purpose  : valid/ready result stream between the decimator and its consumer.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface fir_decim_out_if
    import fir_pkg::*;
#(
    parameter int DATA_W = SAMPLE_W
);

    logic signed [DATA_W-1:0] dout;
    logic                     dout_valid;
    logic                     dout_ready;

    modport master (output dout, output dout_valid, input dout_ready);
    modport slave  (input dout, input dout_valid, output dout_ready);

endinterface

`default_nettype wire

// File: rtl/fir_sample_fifo.sv
// ============================================================================
// Module   : fir_sample_fifo
// Purpose  : Synchronous first-word-fall-through FIFO with occupancy count.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module fir_sample_fifo #(
    parameter int DATA_W = 16,
    parameter int AW     = 3
) (
    input  wire logic              clk,
    input  wire logic              reset,
    input  wire logic              wr_en,
    input  wire logic [DATA_W-1:0] din,
    input  wire logic              rd_en,
    output logic      [DATA_W-1:0] dout,
    output logic      [AW:0]       level,
    output logic                   full,
    output logic                   empty
);

    localparam int c_depth = 1 << AW;

    logic [DATA_W-1:0] r_mem [c_depth];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_level;
    logic              w_rd;
    logic              w_wr;

    assign empty = (r_level == '0);
    assign full  = (r_level == (AW+1)'(c_depth));
    assign w_rd  = rd_en && !empty;
    // A write into a full FIFO is only legal when a read frees the slot on the same edge.
    assign w_wr  = wr_en && (!full || w_rd);

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_level <= r_level + (AW+1)'(w_wr) - (AW+1)'(w_rd);
        end
    end

    assign dout  = r_mem[r_rd_ptr];
    assign level = r_level;

endmodule

`default_nettype wire

// File: rtl/fir_decim_out.sv
// ============================================================================
// Module   : fir_decim_out
// Purpose  : Integrate-and-dump decimator with rounding, FIFO buffering and
//            a valid/ready output stream with sticky overflow.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module fir_decim_out
    import fir_pkg::*;
#(
    parameter int DATA_W     = SAMPLE_W,
    parameter int DECIM_LOG2 = 2,
    parameter int FIFO_AW    = 3
) (
    input  wire logic                     clk,
    input  wire logic                     reset,
    input  wire logic signed [DATA_W-1:0] y_in,
    input  wire logic                     in_en,
    fir_decim_out_if.master               m_if,
    output logic             [FIFO_AW:0]  level,
    output logic                          overflow,
    input  wire logic                     ovf_clr
);

    localparam int c_acc_w = DATA_W + DECIM_LOG2;
    localparam int c_sum_w = c_acc_w + 1;
    localparam int c_ph_w  = (DECIM_LOG2 > 0) ? DECIM_LOG2 : 1;

    localparam logic        [c_ph_w-1:0]  c_last  = c_ph_w'((1 << DECIM_LOG2) - 1);
    localparam logic signed [c_sum_w-1:0] c_round = c_sum_w'(round_term(DECIM_LOG2));

    logic signed [c_acc_w-1:0] r_acc;
    logic        [c_ph_w-1:0]  r_phase;
    logic                      r_ovf;

    logic signed [c_sum_w-1:0] w_sum;
    logic        [DATA_W-1:0]  w_res;
    logic                      w_unused;
    logic                      w_close;
    logic                      w_pop;
    logic                      w_drop;
    logic                      w_wr;
    logic        [DATA_W-1:0]  w_fifo_dout;
    logic                      w_full;
    logic                      w_empty;

    assign w_close = in_en && (r_phase == c_last);

    // One spare bit keeps the rounding add from wrapping at full-scale input.
    assign w_sum    = c_sum_w'(r_acc) + c_sum_w'(y_in) + c_round;
    assign w_res    = w_sum[DECIM_LOG2 +: DATA_W];
    assign w_unused = ^w_sum;

    assign w_pop  = !w_empty && m_if.dout_ready;
    assign w_drop = w_close && w_full && !w_pop;
    assign w_wr   = w_close && !w_drop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_acc   <= '0;
            r_phase <= '0;
        end else if (in_en) begin
            if (w_close) begin
                r_acc   <= '0;
                r_phase <= '0;
            end else begin
                r_acc   <= r_acc + c_acc_w'(y_in);
                r_phase <= r_phase + c_ph_w'(1);
            end
        end
    end

    // A drop on the same edge as a clear wins, so no loss goes unreported.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end else if (ovf_clr) begin
            r_ovf <= 1'b0;
        end
    end

    fir_sample_fifo #(
        .DATA_W (DATA_W),
        .AW     (FIFO_AW)
    ) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .wr_en  (w_wr),
        .din    (w_res),
        .rd_en  (w_pop),
        .dout   (w_fifo_dout),
        .level  (level),
        .full   (w_full),
        .empty  (w_empty)
    );

    // FIFO memory is not reset, so the head word is masked while empty.
    assign m_if.dout       = w_empty ? '0 : w_fifo_dout;
    assign m_if.dout_valid = !w_empty;
    assign overflow        = r_ovf;

endmodule

`default_nettype wire
